// File: rtl/decode_alu.sv
// RV64I integer decoder, 32x64 register file and ALU; decode, read and ALU are purely combinational.
// Latency: 0 cycles to all outputs, register writes land on the next clk edge; no backpressure.
module decode_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        rd_write,
    input  logic [63:0] rd_data,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [63:0] rs1_data,
    output logic [63:0] rs2_data,
    output logic [63:0] imm,
    output logic        use_imm,
    output logic [3:0]  alu_func,
    output logic [2:0]  branch,
    output logic [1:0]  writeback,
    output logic        illegal,
    output logic [63:0] out
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_ADDW = 4'd10;
    localparam logic [3:0] ALU_SUBW = 4'd11;
    localparam logic [3:0] ALU_SLLW = 4'd12;
    localparam logic [3:0] ALU_SRLW = 4'd13;
    localparam logic [3:0] ALU_SRAW = 4'd14;

    localparam logic [2:0] BR_NONE     = 3'd0;
    localparam logic [2:0] BR_TRUE     = 3'd1;
    localparam logic [2:0] BR_FALSE    = 3'd2;
    localparam logic [2:0] BR_ALWAYS   = 3'd3;
    localparam logic [2:0] BR_INDIRECT = 3'd4;

    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_PC   = 2'd2;

    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_OP_32     = 7'h3B;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_JAL       = 7'h6F;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm_i;
    logic [63:0] imm_b;
    logic [63:0] imm_u;
    logic [63:0] imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'h000};
    assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // ---------------------------------------------------------------- decode
    always_comb begin
        rs1       = instr[19:15];
        rs2       = instr[24:20];
        rd        = instr[11:7];
        imm       = '0;
        use_imm   = 1'b0;
        alu_func  = ALU_ADD;
        branch    = BR_NONE;
        writeback = WB_NONE;
        illegal   = 1'b0;

        case (opcode)
            OPC_OP: begin
                writeback = WB_ALU;
                case ({funct7, funct3})
                    {7'h00, 3'd0}: alu_func = ALU_ADD;
                    {7'h20, 3'd0}: alu_func = ALU_SUB;
                    {7'h00, 3'd1}: alu_func = ALU_SLL;
                    {7'h00, 3'd2}: alu_func = ALU_SLT;
                    {7'h00, 3'd3}: alu_func = ALU_SLTU;
                    {7'h00, 3'd4}: alu_func = ALU_XOR;
                    {7'h00, 3'd5}: alu_func = ALU_SRL;
                    {7'h20, 3'd5}: alu_func = ALU_SRA;
                    {7'h00, 3'd6}: alu_func = ALU_OR;
                    {7'h00, 3'd7}: alu_func = ALU_AND;
                    default:       illegal  = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                use_imm   = 1'b1;
                imm       = imm_i;
                writeback = WB_ALU;
                // RV64 shifts carry a 6-bit shamt, so only instr[31:26] qualifies the shift kind
                case (funct3)
                    3'd0: alu_func = ALU_ADD;
                    3'd2: alu_func = ALU_SLT;
                    3'd3: alu_func = ALU_SLTU;
                    3'd4: alu_func = ALU_XOR;
                    3'd6: alu_func = ALU_OR;
                    3'd7: alu_func = ALU_AND;
                    3'd1: begin
                        alu_func = ALU_SLL;
                        illegal  = (instr[31:26] != 6'h00);
                    end
                    default: begin
                        if (instr[31:26] == 6'h00) begin
                            alu_func = ALU_SRL;
                        end else if (instr[31:26] == 6'h10) begin
                            alu_func = ALU_SRA;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP_32: begin
                writeback = WB_ALU;
                case ({funct7, funct3})
                    {7'h00, 3'd0}: alu_func = ALU_ADDW;
                    {7'h20, 3'd0}: alu_func = ALU_SUBW;
                    {7'h00, 3'd1}: alu_func = ALU_SLLW;
                    {7'h00, 3'd5}: alu_func = ALU_SRLW;
                    {7'h20, 3'd5}: alu_func = ALU_SRAW;
                    default:       illegal  = 1'b1;
                endcase
            end
            OPC_OP_IMM_32: begin
                use_imm   = 1'b1;
                imm       = imm_i;
                writeback = WB_ALU;
                case ({funct7, funct3}) inside
                    {7'b???????, 3'd0}: alu_func = ALU_ADDW;
                    {7'h00, 3'd1}:      alu_func = ALU_SLLW;
                    {7'h00, 3'd5}:      alu_func = ALU_SRLW;
                    {7'h20, 3'd5}:      alu_func = ALU_SRAW;
                    default:            illegal  = 1'b1;
                endcase
            end
            OPC_LUI: begin
                rs1       = 5'd0;
                use_imm   = 1'b1;
                imm       = imm_u;
                writeback = WB_ALU;
            end
            OPC_JAL: begin
                imm       = imm_j;
                branch    = BR_ALWAYS;
                writeback = WB_PC;
            end
            OPC_JALR: begin
                use_imm   = 1'b1;
                imm       = imm_i;
                branch    = BR_INDIRECT;
                writeback = WB_PC;
                illegal   = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                imm = imm_b;
                // Taken = TRUE when the ALU result is non-zero, FALSE when it is zero
                case (funct3)
                    3'd0: begin alu_func = ALU_SUB;  branch = BR_FALSE; end
                    3'd1: begin alu_func = ALU_SUB;  branch = BR_TRUE;  end
                    3'd4: begin alu_func = ALU_SLT;  branch = BR_TRUE;  end
                    3'd5: begin alu_func = ALU_SLT;  branch = BR_FALSE; end
                    3'd6: begin alu_func = ALU_SLTU; branch = BR_TRUE;  end
                    3'd7: begin alu_func = ALU_SLTU; branch = BR_FALSE; end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            imm       = '0;
            use_imm   = 1'b0;
            alu_func  = ALU_ADD;
            branch    = BR_NONE;
            writeback = WB_NONE;
        end
    end

    // ---------------------------------------------------------------- register file
    logic [63:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (rd_write && (rd != 5'd0)) begin
            regs[rd] <= rd_data;
        end
    end

    assign rs1_data = (rs1 == 5'd0) ? 64'd0 : regs[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 64'd0 : regs[rs2];

    // ---------------------------------------------------------------- ALU
    logic [63:0] in1;
    logic [63:0] in2;
    logic [5:0]  shamt6;
    logic [4:0]  shamt5;
    logic [31:0] word;

    assign in1    = rs1_data;
    assign in2    = use_imm ? imm : rs2_data;
    assign shamt6 = in2[5:0];
    assign shamt5 = in2[4:0];

    always_comb begin
        word = '0;
        out  = '0;
        case (alu_func)
            ALU_ADD:  out = in1 + in2;
            ALU_SUB:  out = in1 - in2;
            ALU_SLL:  out = in1 << shamt6;
            ALU_SLT:  out = {63'd0, $signed(in1) < $signed(in2)};
            ALU_SLTU: out = {63'd0, in1 < in2};
            ALU_XOR:  out = in1 ^ in2;
            ALU_SRL:  out = in1 >> shamt6;
            ALU_SRA:  out = $signed(in1) >>> shamt6;
            ALU_OR:   out = in1 | in2;
            ALU_AND:  out = in1 & in2;
            ALU_ADDW: begin word = in1[31:0] + in2[31:0];           out = {{32{word[31]}}, word}; end
            ALU_SUBW: begin word = in1[31:0] - in2[31:0];           out = {{32{word[31]}}, word}; end
            ALU_SLLW: begin word = in1[31:0] << shamt5;             out = {{32{word[31]}}, word}; end
            ALU_SRLW: begin word = in1[31:0] >> shamt5;             out = {{32{word[31]}}, word}; end
            ALU_SRAW: begin word = $signed(in1[31:0]) >>> shamt5;   out = {{32{word[31]}}, word}; end
            default:  out = '0;
        endcase
    end

endmodule

// File: tb/tb_decode_alu.sv
// Bench for decode_alu: directed scenarios, then random instructions checked against a mnemonic-level model.
module tb_decode_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        rd_write;
    logic [63:0] rd_data;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] rs1_data, rs2_data, imm, out;
    logic        use_imm, illegal;
    logic [3:0]  alu_func;
    logic [2:0]  branch;
    logic [1:0]  writeback;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] rf_m [32];

    typedef struct packed {
        logic [63:0] imm;
        logic        use_imm;
        logic [3:0]  fn;
        logic [2:0]  br;
        logic [1:0]  wb;
        logic        ill;
        logic [4:0]  rs1;
    } exp_t;

    always #5 clk = ~clk;

    decode_alu dut (
        .clk(clk), .rst(rst), .instr(instr), .rd_write(rd_write), .rd_data(rd_data),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .use_imm(use_imm), .alu_func(alu_func), .branch(branch),
        .writeback(writeback), .illegal(illegal), .out(out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (instr %h)", tag, got, exp, instr);
        end
    endtask

    function automatic string mnem(input logic [31:0] i);
        logic [6:0] f7;
        logic [2:0] f3;
        logic [5:0] hi6;
        f7  = i[31:25];
        f3  = i[14:12];
        hi6 = i[31:26];
        case (i[6:0])
            7'h33: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: return "ADD";  3'd1: return "SLL";
                        3'd2: return "SLT";  3'd3: return "SLTU";
                        3'd4: return "XOR";  3'd5: return "SRL";
                        3'd6: return "OR";   default: return "AND";
                    endcase
                end
                if (f7 == 7'h20 && f3 == 3'd0) return "SUB";
                if (f7 == 7'h20 && f3 == 3'd5) return "SRA";
            end
            7'h13: begin
                case (f3)
                    3'd0: return "ADDI";  3'd2: return "SLTI";
                    3'd3: return "SLTIU"; 3'd4: return "XORI";
                    3'd6: return "ORI";   3'd7: return "ANDI";
                    3'd1: if (hi6 == 6'h00) return "SLLI";
                    default: begin
                        if (hi6 == 6'h00) return "SRLI";
                        if (hi6 == 6'h10) return "SRAI";
                    end
                endcase
            end
            7'h3B: begin
                if (f7 == 7'h00 && f3 == 3'd0) return "ADDW";
                if (f7 == 7'h20 && f3 == 3'd0) return "SUBW";
                if (f7 == 7'h00 && f3 == 3'd1) return "SLLW";
                if (f7 == 7'h00 && f3 == 3'd5) return "SRLW";
                if (f7 == 7'h20 && f3 == 3'd5) return "SRAW";
            end
            7'h1B: begin
                if (f3 == 3'd0) return "ADDIW";
                if (f7 == 7'h00 && f3 == 3'd1) return "SLLIW";
                if (f7 == 7'h00 && f3 == 3'd5) return "SRLIW";
                if (f7 == 7'h20 && f3 == 3'd5) return "SRAIW";
            end
            7'h37: return "LUI";
            7'h6F: return "JAL";
            7'h67: if (f3 == 3'd0) return "JALR";
            7'h63: begin
                case (f3)
                    3'd0: return "BEQ";  3'd1: return "BNE";
                    3'd4: return "BLT";  3'd5: return "BGE";
                    3'd6: return "BLTU"; 3'd7: return "BGEU";
                    default: return "";
                endcase
            end
            default: return "";
        endcase
        return "";
    endfunction

    function automatic int fn_of(input string m);
        case (m)
            "SUB", "BEQ", "BNE":                return 1;
            "SLL", "SLLI":                      return 2;
            "SLT", "SLTI", "BLT", "BGE":        return 3;
            "SLTU", "SLTIU", "BLTU", "BGEU":    return 4;
            "XOR", "XORI":                      return 5;
            "SRL", "SRLI":                      return 6;
            "SRA", "SRAI":                      return 7;
            "OR", "ORI":                        return 8;
            "AND", "ANDI":                      return 9;
            "ADDW", "ADDIW":                    return 10;
            "SUBW":                             return 11;
            "SLLW", "SLLIW":                    return 12;
            "SRLW", "SRLIW":                    return 13;
            "SRAW", "SRAIW":                    return 14;
            default:                            return 0;
        endcase
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t e;
        string m;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [31:0] u32;
        logic signed [63:0] imm_i, imm_b, imm_u, imm_j;
        m     = mnem(i);
        imm_i = $signed(i[31:20]);
        b13   = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        imm_b = $signed(b13);
        j21   = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        imm_j = $signed(j21);
        u32   = {i[31:12], 12'h000};
        imm_u = $signed(u32);
        e     = '0;
        e.rs1 = i[19:15];
        e.ill = (m == "");
        if (!e.ill) begin
            e.fn = 4'(fn_of(m));
            case (i[6:0])
                7'h13, 7'h1B: begin e.use_imm = 1'b1; e.imm = imm_i; e.wb = 2'd1; end
                7'h33, 7'h3B: e.wb = 2'd1;
                7'h37: begin e.use_imm = 1'b1; e.imm = imm_u; e.wb = 2'd1; e.rs1 = 5'd0; end
                7'h6F: begin e.imm = imm_j; e.br = 3'd3; e.wb = 2'd2; end
                7'h67: begin e.use_imm = 1'b1; e.imm = imm_i; e.br = 3'd4; e.wb = 2'd2; end
                default: begin
                    e.imm = imm_b;
                    e.br  = (m == "BNE" || m == "BLT" || m == "BLTU") ? 3'd1 : 3'd2;
                end
            endcase
        end
        return e;
    endfunction

    function automatic logic [63:0] ref_alu(input int fn, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] w;
        logic signed [63:0] sx;
        w = '0;
        case (fn)
            0:  return a + b;
            1:  return a - b;
            2:  return a << b[5:0];
            3:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4:  return (a < b) ? 64'd1 : 64'd0;
            5:  return a ^ b;
            6:  return a >> b[5:0];
            7:  begin sx = $signed(a) >>> b[5:0]; return sx; end
            8:  return a | b;
            9:  return a & b;
            10: w = a[31:0] + b[31:0];
            11: w = a[31:0] - b[31:0];
            12: w = a[31:0] << b[4:0];
            13: w = a[31:0] >> b[4:0];
            default: w = $signed(a[31:0]) >>> b[4:0];
        endcase
        sx = $signed(w);
        return sx;
    endfunction

    task automatic compare_all();
        exp_t e;
        logic [63:0] a, b;
        e = ref_decode(instr);
        a = rf_m[e.rs1];
        b = rf_m[instr[24:20]];
        check("rs1", 64'(rs1), 64'(e.rs1));
        check("rs2", 64'(rs2), 64'(instr[24:20]));
        check("rd", 64'(rd), 64'(instr[11:7]));
        check("rs1_data", rs1_data, a);
        check("rs2_data", rs2_data, b);
        check("imm", imm, e.imm);
        check("use_imm", 64'(use_imm), 64'(e.use_imm));
        check("alu_func", 64'(alu_func), 64'(e.fn));
        check("branch", 64'(branch), 64'(e.br));
        check("writeback", 64'(writeback), 64'(e.wb));
        check("illegal", 64'(illegal), 64'(e.ill));
        check("out", out, ref_alu(int'(e.fn), a, e.use_imm ? e.imm : b));
    endtask

    task automatic apply(input logic [31:0] i, input logic we, input logic [63:0] wd, input logic r);
        instr    = i;
        rd_write = we;
        rd_data  = wd;
        rst      = r;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) rf_m[k] = '0;
        end else if (rd_write && instr[11:7] != 5'd0) begin
            rf_m[instr[11:7]] = rd_data;
        end
        #1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 13))
            0: i[6:0] = 7'h33;  1: i[6:0] = 7'h13;  2: i[6:0] = 7'h3B;
            3: i[6:0] = 7'h1B;  4: i[6:0] = 7'h37;  5: i[6:0] = 7'h6F;
            6: i[6:0] = 7'h67;  7: i[6:0] = 7'h63;  8: i[6:0] = 7'h03;
            9: i[6:0] = 7'h23;  10: i[6:0] = 7'h17; 11: i[6:0] = 7'h0F;
            12: i[6:0] = 7'h73; default: ;
        endcase
        if ($urandom_range(0, 4) != 0) begin
            if (i[6:0] == 7'h33 || i[6:0] == 7'h3B || i[6:0] == 7'h1B)
                i[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            if (i[6:0] == 7'h13 && (i[14:12] == 3'd1 || i[14:12] == 3'd5))
                i[31:26] = ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h00;
            if (i[6:0] == 7'h67)
                i[14:12] = 3'd0;
        end
        if ($urandom_range(0, 3) != 0) begin
            i[19:15] = 5'($urandom_range(0, 7));
            i[24:20] = 5'($urandom_range(0, 7));
            i[11:7]  = 5'($urandom_range(0, 7));
        end
        return i;
    endfunction

    initial begin
        apply(32'h0000_0013, 1'b0, 64'd0, 1'b1);
        tick();

        // reset clears registers and swallows a concurrent write
        apply(32'h0000_0293, 1'b1, 64'hABCD, 1'b0);
        tick();
        apply(32'h0002_8013, 1'b0, 64'd0, 1'b0);
        check("x5_written", rs1_data, 64'hABCD);
        tick();
        apply(32'h0000_0293, 1'b1, 64'h77, 1'b1);
        compare_all();
        tick();
        apply(32'h0002_8013, 1'b0, 64'd0, 1'b0);
        check("rst_rs1", 64'(rs1), 64'd5);
        check("rst_clears_x5", rs1_data, 64'd0);
        tick();

        // write x1=5, then ADDI x2,x1,-3
        apply(32'h0000_0093, 1'b1, 64'd5, 1'b0);
        tick();
        apply(32'hFFD0_8113, 1'b0, 64'd0, 1'b0);
        check("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFD);
        check("addi_use_imm", 64'(use_imm), 64'd1);
        check("addi_out", out, 64'd2);
        check("addi_wb", 64'(writeback), 64'd1);
        check("addi_illegal", 64'(illegal), 64'd0);
        compare_all();
        tick();

        // x2=7, SUB x3,x1,x2 underflows
        apply(32'h0000_0113, 1'b1, 64'd7, 1'b0);
        tick();
        apply(32'h4020_81B3, 1'b0, 64'd0, 1'b0);
        check("sub_func", 64'(alu_func), 64'd1);
        check("sub_out", out, 64'hFFFF_FFFF_FFFF_FFFE);
        compare_all();
        tick();

        // BEQ x1,x1,+8
        apply(32'h0010_8463, 1'b0, 64'd0, 1'b0);
        check("beq_imm", imm, 64'd8);
        check("beq_func", 64'(alu_func), 64'd1);
        check("beq_branch", 64'(branch), 64'd2);
        check("beq_out", out, 64'd0);
        check("beq_wb", 64'(writeback), 64'd0);
        compare_all();
        tick();

        // write to x0 is discarded
        apply(32'h0000_0013, 1'b1, 64'h1234, 1'b0);
        tick();
        apply(32'h0000_0013, 1'b0, 64'd0, 1'b0);
        check("x0_reads_zero", rs1_data, 64'd0);
        tick();

        // all-zero word is illegal
        apply(32'h0000_0000, 1'b0, 64'd0, 1'b0);
        check("ill_flag", 64'(illegal), 64'd1);
        check("ill_branch", 64'(branch), 64'd0);
        check("ill_wb", 64'(writeback), 64'd0);
        compare_all();
        tick();

        for (int n = 0; n < 400; n++) begin
            apply(gen_instr(), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 39) == 0));
            compare_all();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_alu.md
DECODE_ALU -- requirements
Module: decode_alu

Interface
REQ-001 The block SHALL have these ports, each `name  direction  width  meaning`, with clock and reset first:
- clk  in  1  the block's single clock.
- rst  in  1  reset, synchronous and active-high.
- instr  in  32  RV64I instruction word.
- rd_write  in  1  register-file write enable.
- rd_data  in  64  register-file write data.
- rs1, rs2, rd  out  5 each  register fields instr[19:15], instr[24:20], instr[11:7].
- rs1_data, rs2_data  out  64  register-file read data.
- imm  out  64  sign-extended immediate.
- use_imm  out  1  ALU operand 2 comes from imm instead of rs2_data.
- alu_func  out  4  ALU operation.
- branch  out  3  branch kind.
- writeback  out  2  writeback source.
- illegal  out  1  instruction is not supported.
- out  out  64  ALU result.

REQ-002 Encodings SHALL be:
- alu_func: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, ADDW=10, SUBW=11, SLLW=12, SRLW=13, SRAW=14.
- branch: NONE=0, TRUE=1, FALSE=2, ALWAYS=3, INDIRECT=4.
- writeback: NONE=0, ALU=1, PC=2.

Function
REQ-003 All outputs except register contents SHALL be combinational from instr and the register file; decode and ALU latency is zero cycles.

REQ-004 The register file SHALL hold 32 x 64-bit registers with combinational reads.
- x0 always reads 0.
- There is no write-to-read bypass: a same-cycle read returns the old value.

REQ-005 On posedge clk with rd_write=1, rst=0 and rd!=0, register[rd] SHALL be loaded with rd_data; writes to x0 are discarded.

REQ-006 The ALU SHALL use in1=rs1_data and in2=(use_imm ? imm : rs2_data), with all arithmetic modulo 2^64.

REQ-007 ALU operations SHALL be:
- SLT and SLTU produce 1 or 0, signed and unsigned respectively.
- SLL, SRL and SRA use in2[5:0] as the shift amount.
- ADDW, SUBW, SLLW, SRLW and SRAW operate on in1[31:0], use in2[4:0] as the shift amount, and sign-extend the 32-bit result.

REQ-008 Immediates SHALL use the standard RISC-V I, S, B, U and J formats, sign-extended to 64 bits. B and J immediates are byte offsets with bit 0 = 0. Types with no immediate output imm=0.

REQ-009 Opcode 0x33 (OP) SHALL decode ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND by funct3/funct7, with use_imm=0 and writeback=ALU.

REQ-010 Opcode 0x13 (OP-IMM) SHALL decode ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI and SRAI, with use_imm=1 and writeback=ALU.
- Shift instructions use a 6-bit shamt.
- SRAI is selected by instr[30].

REQ-011 Opcodes 0x3B and 0x1B SHALL decode ADDW/SUBW/SLLW/SRLW/SRAW and ADDIW/SLLIW/SRLIW/SRAIW in the same way as REQ-009 and REQ-010.

REQ-012 LUI (0x37) SHALL decode as ADD with use_imm=1, writeback=ALU, and the rs1 output forced to 0, so that out=imm.

REQ-013 JAL (0x6F) SHALL decode as branch=ALWAYS, writeback=PC, imm=J-immediate.

REQ-014 JALR (0x67) SHALL decode as ADD with use_imm=1, branch=INDIRECT, writeback=PC.

REQ-015 BRANCH (0x63) SHALL decode with use_imm=0, writeback=NONE, imm=B-immediate, as follows:
- BEQ: SUB, FALSE.
- BNE: SUB, TRUE.
- BLT: SLT, TRUE.
- BGE: SLT, FALSE.
- BLTU: SLTU, TRUE.
- BGEU: SLTU, FALSE.

REQ-016 All other opcodes and invalid funct combinations, including AUIPC, loads, stores, FENCE and SYSTEM, SHALL set illegal=1 with use_imm=0, alu_func=ADD, branch=NONE and writeback=NONE. illegal=0 otherwise.

REQ-017 Non-branch instructions SHALL output branch=NONE; non-ALU, non-PC writebacks SHALL output writeback=NONE.

Reset
REQ-018 On posedge clk with rst=1, all 32 registers SHALL be cleared to 0 and any rd_write in that cycle is ignored.

REQ-019 Combinational outputs SHALL be unaffected by rst except through cleared register contents.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset clears registers: rst=1 for one clock, then any instr reading x5 -> rs1_data=0.
- Write then ADDI: write x1=5 (instr rd=1, rd_write=1, rd_data=5), then instr=0xFFD08113 (ADDI x2,x1,-3) -> imm=0xFFFFFFFFFFFFFFFD, use_imm=1, out=2, writeback=ALU, illegal=0.
- SUB underflow: x1=5, x2=7, instr=0x402081B3 (SUB) -> alu_func=SUB, out=0xFFFFFFFFFFFFFFFE.
- BEQ taken condition: instr=0x00108463 (BEQ x1,x1,+8) -> imm=8, alu_func=SUB, branch=FALSE, out=0, writeback=NONE.
- x0 write discarded: write to x0 with rd_data=0x1234 -> rs1_data reads 0 for x0.
- Illegal instruction: instr=0x00000000 -> illegal=1, branch=NONE, writeback=NONE.
